// File: rtl/stall_md_ctrl_if.sv
// ID/EX hazard and md-unit sequencing signals between the ID stage and the
// stall controller. master = pipeline side, slave = controller side.
interface stall_md_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic       id_md_use;
  logic [4:0] ex_waddr;
  logic [1:0] ex_tnew;
  logic [4:0] mem_waddr;
  logic [1:0] mem_tnew;
  logic       ex_md_start;
  logic [1:0] ex_md_op;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_flush;
  logic       md_busy;
  logic       stall;

  modport master (
    output id_rs, id_rt, tuse_rs, tuse_rt, id_md_use,
    output ex_waddr, ex_tnew, mem_waddr, mem_tnew,
    output ex_md_start, ex_md_op,
    input  pc_en, ifid_en, idex_flush, md_busy, stall
  );

  modport slave (
    input  id_rs, id_rt, tuse_rs, tuse_rt, id_md_use,
    input  ex_waddr, ex_tnew, mem_waddr, mem_tnew,
    input  ex_md_start, ex_md_op,
    output pc_en, ifid_en, idex_flush, md_busy, stall
  );
endinterface

// File: rtl/stall_md_ctrl.sv
// ID/EX stall controller: Tuse/Tnew hazards plus mult/div busy scheduling.
// Optional STALL_STATS_EN adds stall_count and md_stall_count outputs.
module stall_md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  stall_md_ctrl_if.slave bus
`ifdef STALL_STATS_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] md_stall_count
`endif
);

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic       rs_hz;
  logic       rt_hz;
  logic       md_hz;
  logic       stall_w;

  // State and remaining-cycle counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: a start (re)loads the latency, else count down while busy
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (bus.ex_md_start) begin
      state_n = BUSY;
      cnt_n   = bus.ex_md_op[1] ? DIV_LAT : MULT_LAT;
    end else if (state == BUSY) begin
      if (cnt == 4'd1) begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end else begin
        cnt_n = cnt - 4'd1;
      end
    end
  end

  // Hazard detection and pipeline enables
  always_comb begin
    rs_hz = (bus.id_rs != 5'd0) &&
            ((bus.id_rs == bus.ex_waddr &&
              bus.ex_tnew > bus.tuse_rs) ||
             (bus.id_rs == bus.mem_waddr &&
              bus.mem_tnew > bus.tuse_rs));
    rt_hz = (bus.id_rt != 5'd0) &&
            ((bus.id_rt == bus.ex_waddr &&
              bus.ex_tnew > bus.tuse_rt) ||
             (bus.id_rt == bus.mem_waddr &&
              bus.mem_tnew > bus.tuse_rt));
    bus.md_busy    = (state == BUSY) || bus.ex_md_start;
    md_hz          = bus.id_md_use && bus.md_busy;
    stall_w        = rs_hz || rt_hz || md_hz;
    bus.stall      = stall_w;
    bus.pc_en      = ~stall_w;
    bus.ifid_en    = ~stall_w;
    bus.idex_flush = stall_w;
  end

`ifdef STALL_STATS_EN
  // Saturating stall counters; md count only when md is the sole cause
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count    <= 32'd0;
      md_stall_count <= 32'd0;
    end else begin
      if (stall_w && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
      if (md_hz && !rs_hz && !rt_hz &&
          md_stall_count != 32'hFFFF_FFFF)
        md_stall_count <= md_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stall_md_ctrl.sv
// Scoreboard bench for stall_md_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares.
module tb_stall_md_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;

  stall_md_ctrl_if bus ();

`ifdef STALL_STATS_EN
  logic [31:0] stall_count;
  logic [31:0] md_stall_count;
`endif

  stall_md_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef STALL_STATS_EN
    ,
    .stall_count(stall_count),
    .md_stall_count(md_stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [4:0] v;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // expected vector: {stall, pc_en, ifid_en, idex_flush, md_busy}
  task automatic expect_o(input string nm, input logic s,
                          input logic b);
    exp_t e;
    e.nm = nm;
    e.v  = {s, ~s, ~s, s, b};
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.id_rs       = 5'd0;
    bus.id_rt       = 5'd0;
    bus.tuse_rs     = 2'd3;
    bus.tuse_rt     = 2'd3;
    bus.id_md_use   = 1'b0;
    bus.ex_waddr    = 5'd0;
    bus.ex_tnew     = 2'd0;
    bus.mem_waddr   = 5'd0;
    bus.mem_tnew    = 2'd0;
    bus.ex_md_start = 1'b0;
    bus.ex_md_op    = 2'd0;
  endtask

  // Monitor: compare DUT outputs against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] got;
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = {bus.stall, bus.pc_en, bus.ifid_en,
             bus.idex_flush, bus.md_busy};
      tests++;
      if (got !== e.v) begin
        fails++;
        $display("FAIL %s got=%b exp=%b", e.nm, got, e.v);
      end
    end
  end

  initial begin
    quiet();
    reset = 1'b1;
    tick();
    expect_o("reset_c1", 1'b0, 1'b0);
    tick();
    expect_o("reset_c2", 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    expect_o("idle", 1'b0, 1'b0);

    // EX hazard then Tnew drops
    tick();
    bus.id_rs = 5'd8; bus.tuse_rs = 2'd0;
    bus.ex_waddr = 5'd8; bus.ex_tnew = 2'd2;
    expect_o("ex_hz", 1'b1, 1'b0);
    tick();
    bus.ex_tnew = 2'd0;
    expect_o("ex_tnew0", 1'b0, 1'b0);

    // MEM hazard on rt, then equal tnew/tuse (no stall)
    tick();
    quiet();
    bus.id_rt = 5'd9; bus.tuse_rt = 2'd1;
    bus.mem_waddr = 5'd9; bus.mem_tnew = 2'd2;
    expect_o("mem_rt_hz", 1'b1, 1'b0);
    tick();
    bus.tuse_rt = 2'd2;
    expect_o("mem_rt_eq", 1'b0, 1'b0);
    tick();
    bus.id_rt = 5'd10;
    bus.tuse_rt = 2'd0;
    expect_o("mem_rt_diff", 1'b0, 1'b0);

    // Register 0 never hazards
    tick();
    quiet();
    bus.id_rs = 5'd0; bus.tuse_rs = 2'd0;
    bus.ex_waddr = 5'd0; bus.ex_tnew = 2'd2;
    expect_o("zero_reg", 1'b0, 1'b0);

    // Multiply: 6 busy cycles with md use
    tick();
    quiet();
    bus.id_md_use = 1'b1;
    bus.ex_md_start = 1'b1; bus.ex_md_op = 2'b00;
    expect_o("mul_c0", 1'b1, 1'b1);
    for (int i = 1; i < 6; i++) begin
      tick();
      bus.ex_md_start = 1'b0;
      expect_o($sformatf("mul_c%0d", i), 1'b1, 1'b1);
    end
    tick();
    expect_o("mul_c6", 1'b0, 1'b0);

    // Divide aborted by reset after 4 busy cycles
    tick();
    bus.ex_md_start = 1'b1; bus.ex_md_op = 2'b10;
    expect_o("divr_c0", 1'b1, 1'b1);
    for (int i = 1; i < 5; i++) begin
      tick();
      bus.ex_md_start = 1'b0;
      expect_o($sformatf("divr_c%0d", i), 1'b1, 1'b1);
    end
    tick();
    reset = 1'b1;
    expect_o("divr_rst", 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    expect_o("divr_after", 1'b0, 1'b0);

    // Divide unused by ID: busy 11 cycles, no stall
    tick();
    quiet();
    bus.ex_md_start = 1'b1; bus.ex_md_op = 2'b11;
    expect_o("div_c0", 1'b0, 1'b1);
    for (int i = 1; i < 11; i++) begin
      tick();
      bus.ex_md_start = 1'b0;
      expect_o($sformatf("div_c%0d", i), 1'b0, 1'b1);
    end
    tick();
    expect_o("div_c11", 1'b0, 1'b0);

    // Stall and start together; restart while busy
    tick();
    bus.id_rs = 5'd4; bus.tuse_rs = 2'd0;
    bus.ex_waddr = 5'd4; bus.ex_tnew = 2'd1;
    bus.ex_md_start = 1'b1; bus.ex_md_op = 2'b01;
    expect_o("hz_and_start", 1'b1, 1'b1);
    tick();
    quiet();
    bus.ex_md_start = 1'b1; bus.ex_md_op = 2'b10;
    expect_o("restart", 1'b0, 1'b1);
    for (int i = 1; i < 11; i++) begin
      tick();
      bus.ex_md_start = 1'b0;
      expect_o($sformatf("rst_c%0d", i), 1'b0, 1'b1);
    end
    tick();
    expect_o("rst_end", 1'b0, 1'b0);

`ifdef STALL_STATS_EN
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.id_md_use = 1'b1;
    bus.ex_md_start = 1'b1; bus.ex_md_op = 2'b00;
    for (int i = 1; i < 7; i++) begin
      tick();
      bus.ex_md_start = 1'b0;
    end
    tests++;
    if (stall_count !== 32'd6 || md_stall_count !== 32'd6) begin
      fails++;
      $display("FAIL stats_mul got=%0d/%0d exp=6/6",
               stall_count, md_stall_count);
    end
    quiet();
    bus.id_rs = 5'd8; bus.tuse_rs = 2'd0;
    bus.ex_waddr = 5'd8; bus.ex_tnew = 2'd2;
    tick();
    tick();
    quiet();
    tick();
    tests++;
    if (stall_count !== 32'd8 || md_stall_count !== 32'd6) begin
      fails++;
      $display("FAIL stats_hz got=%0d/%0d exp=8/6",
               stall_count, md_stall_count);
    end
`endif

    // Bounded drain of the scoreboard
    for (int i = 0; i < 4; i++)
      if (q.size() > 0) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
